// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Owns the single register-file write port and shares it between the in-order
// pipeline writeback path (the WB stage mux output) and the multi-cycle
// multiply/divide unit. The pipeline always wins. Multiply/divide results wait
// in a small FIFO and drain into slots where the pipeline does not write. If a
// buffered result waits too long, stall_req asks the pipeline to freeze
// upstream of WB so that bubbles reach this block and the FIFO can drain.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   wb_RegWrite   pipeline WB instruction writes a register
//   wb_write_reg  pipeline WB destination register
//   wb_data       pipeline WB write data
//   md_valid      multiply/divide unit offers a result
//   md_reg        destination register of the offered result
//   md_data       offered result value
//   md_ready      FIFO can accept (transfer on md_valid & md_ready)
//   chk_reg       register queried by the hazard unit
//   chk_hit       chk_reg has a result still pending in the FIFO
//   rf_we         register-file write enable (registered)
//   rf_wa         register-file write address (registered)
//   rf_wd         register-file write data (registered)
//   stall_req     request to freeze the pipeline upstream of WB (registered)
//   fifo_count    current FIFO occupancy
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_RegWrite,
  input  logic [4:0]               wb_write_reg,
  input  logic [31:0]              wb_data,
  input  logic                     md_valid,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  output logic                     md_ready,
  input  logic [4:0]               chk_reg,
  output logic                     chk_hit,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wd,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage: payload arrays plus a per-entry valid flag used by the
  // hazard lookup, so the lookup never has to decode the pointer window.
  logic [4:0]       fifo_reg  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic             wb_win;
  logic             fifo_empty;
  logic             fifo_full;
  logic             md_accept;
  logic             push;
  logic             pop;

  // A pipeline write to $0 is not a real write, so it leaves the slot free
  // for the FIFO. Results for $0 are accepted from the unit but dropped here
  // instead of being enqueued. Readiness comes from the registered count
  // only, so a pop in the same cycle never lets a push into a full FIFO.
  assign wb_win     = wb_RegWrite & (wb_write_reg != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign md_ready   = ~fifo_full;
  assign md_accept  = md_valid & md_ready;
  assign push       = md_accept & (md_reg != 5'd0);
  assign pop        = ~wb_win & ~fifo_empty;
  assign fifo_count = count;

  // Payload write. No reset needed: entry_valid and count decide whether
  // anything stored here is ever looked at.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= md_reg;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  // Pointer, occupancy and valid-flag bookkeeping. DEPTH is a power of two,
  // so the pointers wrap naturally. Push and pop never hit the same entry
  // in one cycle: that would need the FIFO to be both empty and non-empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + AW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr              <= rd_ptr + AW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Register-file write port. The pipeline has strict priority; otherwise
  // the oldest buffered result goes out. In an idle slot only the enable
  // drops and the address/data hold their previous values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= 5'd0;
      rf_wd <= 32'd0;
    end else if (wb_win) begin
      rf_we <= 1'b1;
      rf_wa <= wb_write_reg;
      rf_wd <= wb_data;
    end else if (pop) begin
      rf_we <= 1'b1;
      rf_wa <= fifo_reg[rd_ptr];
      rf_wd <= fifo_data[rd_ptr];
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Starvation tracking. The counter measures how long a non-empty FIFO has
  // gone without draining and saturates at the limit. Once it sits at the
  // limit, stall_req rises on the following edge and stays up until a pop
  // actually happens; the pipeline then feeds bubbles, so that pop follows
  // right away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      if (pop) begin
        stall_req <= 1'b0;
      end else if (starve_cnt == SW'(STARVE_LIMIT)) begin
        stall_req <= 1'b1;
      end
    end
  end

  // Hazard lookup over the pending entries. Register $0 never matches; it
  // cannot be in the FIFO anyway, and reads of $0 are always safe.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (fifo_reg[i] == chk_reg) && (chk_reg != 5'd0)) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4). A table
// of consecutive cycles covers priority, $0 handling and back-pressure; the
// starvation stall and a mid-operation reset are driven by hand. Inputs are
// driven on the falling edge, combinational outputs are checked just before
// the rising edge and registered outputs 1 ns after it.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int NVEC         = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_RegWrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  chk_reg;
  logic        chk_hit;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_dat;
    logic        md_v;
    logic [4:0]  md_r;
    logic [31:0] md_d;
    logic [4:0]  chk;
    logic        exp_ready;
    logic        exp_hit;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [1:0]  exp_cnt;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [NVEC];

  wb_port_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb_RegWrite(wb_RegWrite),
    .wb_write_reg(wb_write_reg),
    .wb_data(wb_data),
    .md_valid(md_valid),
    .md_reg(md_reg),
    .md_data(md_data),
    .md_ready(md_ready),
    .chk_reg(chk_reg),
    .chk_hit(chk_hit),
    .rf_we(rf_we),
    .rf_wa(rf_wa),
    .rf_wd(rf_wd),
    .stall_req(stall_req),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIn(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] cr);
    @(negedge clk);
    wb_RegWrite  = we;
    wb_write_reg = wr;
    wb_data      = wd;
    md_valid     = mv;
    md_reg       = mr;
    md_data      = md;
    chk_reg      = cr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    driveIn(v.wb_we, v.wb_reg, v.wb_dat, v.md_v, v.md_r, v.md_d, v.chk);
    #4;
    checkOutput($sformatf("v%0d md_ready", idx), {31'b0, md_ready}, {31'b0, v.exp_ready});
    checkOutput($sformatf("v%0d chk_hit", idx), {31'b0, chk_hit}, {31'b0, v.exp_hit});
    stepCycle();
    checkOutput($sformatf("v%0d rf_we", idx), {31'b0, rf_we}, {31'b0, v.exp_we});
    checkOutput($sformatf("v%0d rf_wa", idx), {27'b0, rf_wa}, {27'b0, v.exp_wa});
    checkOutput($sformatf("v%0d rf_wd", idx), rf_wd, v.exp_wd);
    checkOutput($sformatf("v%0d fifo_count", idx), {30'b0, fifo_count}, {30'b0, v.exp_cnt});
    checkOutput($sformatf("v%0d stall_req", idx), {31'b0, stall_req}, {31'b0, v.exp_stall});
  endtask

  initial begin
    // Consecutive cycles starting from reset state (rf_wa=0, rf_wd=0, empty).
    //            wbwe  wbreg  wbdata         mdv   mdreg  mddata         chk    rdy   hit   we    wa     wd             cnt   stall
    // WB priority with a simultaneous md push, then the buffered result drains.
    vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 1'b1, 5'd9,  32'h12345678, 5'd9,  1'b1, 1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 2'd1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  32'h12345678, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  1'b1, 1'b0, 1'b0, 5'd9,  32'h12345678, 2'd0, 1'b0};
    // md result for $0 is dropped.
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  32'h12345678, 2'd0, 1'b0};
    // WB write to $0 is an idle slot: reg 7 enqueues, then drains in the next $0 slot.
    vecs[4]  = '{1'b1, 5'd0,  32'h0000AAAA, 1'b1, 5'd7,  32'h00000077, 5'd7,  1'b1, 1'b0, 1'b0, 5'd9,  32'h12345678, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 5'd0,  32'h0000BBBB, 1'b0, 5'd0,  32'h0,        5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  32'h00000077, 2'd0, 1'b0};
    // Full / back-pressure with WB busy: 3 and 4 accepted, 5 refused.
    vecs[6]  = '{1'b1, 5'd10, 32'h000000A0, 1'b1, 5'd3,  32'h00000033, 5'd3,  1'b1, 1'b0, 1'b1, 5'd10, 32'h000000A0, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 5'd11, 32'h000000A1, 1'b1, 5'd4,  32'h00000044, 5'd3,  1'b1, 1'b1, 1'b1, 5'd11, 32'h000000A1, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 5'd12, 32'h000000A2, 1'b1, 5'd5,  32'h00000055, 5'd4,  1'b0, 1'b1, 1'b1, 5'd12, 32'h000000A2, 2'd2, 1'b0};
    // WB idle: 3 drains while full so 5 still waits; then 4 drains as 5 lands.
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h00000055, 5'd5,  1'b0, 1'b0, 1'b1, 5'd3,  32'h00000033, 2'd1, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h00000055, 5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  32'h00000044, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  32'h00000055, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 5'd5,  32'h00000055, 2'd0, 1'b0};

    // Reset held for two cycles with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wb_RegWrite  = 1'($urandom);
      wb_write_reg = 5'($urandom);
      wb_data      = $urandom;
      md_valid     = 1'($urandom);
      md_reg       = 5'($urandom);
      md_data      = $urandom;
      chk_reg      = 5'($urandom);
      stepCycle();
    end
    checkOutput("reset rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("reset rf_wa", {27'b0, rf_wa}, 32'd0);
    checkOutput("reset rf_wd", rf_wd, 32'd0);
    checkOutput("reset stall_req", {31'b0, stall_req}, 32'd0);
    checkOutput("reset md_ready", {31'b0, md_ready}, 32'd1);
    checkOutput("reset fifo_count", {30'b0, fifo_count}, 32'd0);
    checkOutput("reset chk_hit", {31'b0, chk_hit}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    wb_RegWrite  = 1'b0;
    wb_write_reg = 5'd0;
    wb_data      = 32'd0;
    md_valid     = 1'b0;
    md_reg       = 5'd0;
    md_data      = 32'd0;
    chk_reg      = 5'd0;
    stepCycle();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Starvation: one entry waits behind a busy pipeline. The counter reaches
    // the limit after four non-drained edges, stall_req rises on the fifth.
    driveIn(1'b1, 5'd20, 32'h100, 1'b1, 5'd21, 32'h2121, 5'd21);
    stepCycle();
    checkOutput("starve enq count", {30'b0, fifo_count}, 32'd1);
    checkOutput("starve enq rf_wa", {27'b0, rf_wa}, 32'd20);
    for (int i = 1; i <= 4; i++) begin
      driveIn(1'b1, 5'(20 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd21);
      stepCycle();
      checkOutput($sformatf("starve wait%0d stall_req", i), {31'b0, stall_req}, 32'd0);
      checkOutput($sformatf("starve wait%0d count", i), {30'b0, fifo_count}, 32'd1);
    end
    driveIn(1'b1, 5'd25, 32'h105, 1'b0, 5'd0, 32'd0, 5'd21);
    stepCycle();
    checkOutput("starve stall_req set", {31'b0, stall_req}, 32'd1);
    checkOutput("starve rf_wa busy", {27'b0, rf_wa}, 32'd25);
    driveIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd21);
    #4;
    checkOutput("starve chk_hit pending", {31'b0, chk_hit}, 32'd1);
    stepCycle();
    checkOutput("starve drain rf_we", {31'b0, rf_we}, 32'd1);
    checkOutput("starve drain rf_wa", {27'b0, rf_wa}, 32'd21);
    checkOutput("starve drain rf_wd", rf_wd, 32'h2121);
    checkOutput("starve stall_req clear", {31'b0, stall_req}, 32'd0);
    checkOutput("starve drain count", {30'b0, fifo_count}, 32'd0);
    driveIn(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd21);
    stepCycle();
    checkOutput("starve idle rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("starve idle stall_req", {31'b0, stall_req}, 32'd0);

    // Mid-operation reset: FIFO full and stall_req raised, then reset.
    driveIn(1'b1, 5'd22, 32'h200, 1'b1, 5'd23, 32'h2323, 5'd0);
    stepCycle();
    driveIn(1'b1, 5'd22, 32'h201, 1'b1, 5'd24, 32'h2424, 5'd0);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      driveIn(1'b1, 5'd22, 32'h202 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd23);
      stepCycle();
    end
    checkOutput("midrst pre count", {30'b0, fifo_count}, 32'd2);
    checkOutput("midrst pre stall_req", {31'b0, stall_req}, 32'd1);
    checkOutput("midrst pre chk_hit", {31'b0, chk_hit}, 32'd1);
    @(negedge clk);
    rst_n       = 1'b0;
    wb_RegWrite = 1'b0;
    md_valid    = 1'b0;
    chk_reg     = 5'd23;
    stepCycle();
    checkOutput("midrst count", {30'b0, fifo_count}, 32'd0);
    checkOutput("midrst stall_req", {31'b0, stall_req}, 32'd0);
    checkOutput("midrst rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("midrst md_ready", {31'b0, md_ready}, 32'd1);
    checkOutput("midrst chk_hit", {31'b0, chk_hit}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput($sformatf("midrst after%0d rf_we", i), {31'b0, rf_we}, 32'd0);
      checkOutput($sformatf("midrst after%0d count", i), {30'b0, fifo_count}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against an unexpected hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
